count_step_monitor: RTL and testbench

Downstream checker for the 4-bit up/down counter. Each cycle it samples the counter's `Count`, `UpOrDown` and counter reset, and classifies the step since the previous sample as a legal step, a wrap-around or an error. It keeps saturating wrap and error tallies and queues classified events to a consumer through a valid/ready FIFO interface. It sits beside the counter on the same clock and reports on it only; it never drives the counter.

---
 rtl/count_mon_pkg.sv | 15 +
 rtl/count_evt_fifo.sv | 46 ++++
 rtl/count_step_monitor.sv | 135 +++++++++++++
 tb/tb_count_step_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and default widths for the count_step_monitor block.
package count_mon_pkg;

    typedef enum logic [1:0] {
        EVT_WRAP_UP = 2'b00,
        EVT_WRAP_DN = 2'b01,
        EVT_DIR_ERR = 2'b10,
        EVT_JUMP    = 2'b11
    } evt_code_t;

    localparam int CNT_W_DEF     = 4;
    localparam int TALLY_W_DEF   = 8;
    localparam int EVT_DEPTH_DEF = 4;

endpackage

// File: rtl/count_evt_fifo.sv
// Synchronous show-ahead FIFO; data_out reads zero while empty.
module count_evt_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);

    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/count_step_monitor.sv
// Classifies each step of an up/down counter, tallies wraps/errors and queues events.
// Define STEP_MON_ERR_EN to detect, count and queue DIR_ERR and JUMP events.
module count_step_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int TALLY_W   = TALLY_W_DEF,
    parameter int EVT_DEPTH = EVT_DEPTH_DEF
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   Count,
    input  logic               UpOrDown,
    input  logic               CntReset,
    output logic               evt_valid,
    output logic [1:0]         evt_code,
    output logic [CNT_W-1:0]   evt_cnt,
    input  logic               evt_ready,
    output logic [TALLY_W-1:0] up_wraps,
    output logic [TALLY_W-1:0] dn_wraps,
    output logic [TALLY_W-1:0] err_cnt,
    output logic               ovf
);
    localparam logic [CNT_W-1:0]   CNT_ONE = 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [TALLY_W-1:0] TAL_ONE = 1;
    localparam logic [TALLY_W-1:0] TAL_MAX = '1;

    logic [CNT_W-1:0] prev_cnt;
    logic             prev_dir;
    logic             prev_clr;
    logic             primed;

    logic             step_up;
    logic             step_dn;
    logic             push;
    evt_code_t        code;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W+1:0] head;

    assign step_up = (Count == prev_cnt + CNT_ONE);
    assign step_dn = (Count == prev_cnt - CNT_ONE);

    always_comb begin
        push = 1'b0;
        code = EVT_WRAP_UP;
        if (primed) begin
            if (prev_clr) begin
`ifdef STEP_MON_ERR_EN
                if (Count != '0) begin
                    push = 1'b1;
                    code = EVT_JUMP;
                end
`endif
            end else if (prev_dir && step_up) begin
                if (prev_cnt == CNT_MAX && Count == '0) begin
                    push = 1'b1;
                    code = EVT_WRAP_UP;
                end
            end else if (!prev_dir && step_dn) begin
                if (prev_cnt == '0 && Count == CNT_MAX) begin
                    push = 1'b1;
                    code = EVT_WRAP_DN;
                end
`ifdef STEP_MON_ERR_EN
            end else if (step_up || step_dn) begin
                push = 1'b1;
                code = EVT_DIR_ERR;
            end else begin
                push = 1'b1;
                code = EVT_JUMP;
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            prev_cnt <= '0;
            prev_dir <= 1'b0;
            prev_clr <= 1'b0;
            primed   <= 1'b0;
            up_wraps <= '0;
            dn_wraps <= '0;
            ovf      <= 1'b0;
        end else begin
            prev_cnt <= Count;
            prev_dir <= UpOrDown;
            prev_clr <= CntReset;
            primed   <= 1'b1;
            if (push && code == EVT_WRAP_UP && up_wraps != TAL_MAX) up_wraps <= up_wraps + TAL_ONE;
            if (push && code == EVT_WRAP_DN && dn_wraps != TAL_MAX) dn_wraps <= dn_wraps + TAL_ONE;
            if (push && fifo_full && !pop) ovf <= 1'b1;
        end
    end

`ifdef STEP_MON_ERR_EN
    logic [TALLY_W-1:0] err_q;
    always_ff @(posedge Clk) begin
        if (!reset) begin
            err_q <= '0;
        end else if (push && code[1] && err_q != TAL_MAX) begin
            err_q <= err_q + TAL_ONE;
        end
    end
    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

    // Handshake: evt_valid is high while the FIFO holds an entry; the head transfers on
    // an edge where evt_valid && evt_ready, and evt_code/evt_cnt hold until then.
    assign pop = evt_valid && evt_ready;

    count_evt_fifo #(
        .WIDTH (CNT_W + 2),
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  ({code, Count}),
        .data_out (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head[CNT_W+1:CNT_W];
    assign evt_cnt   = head[CNT_W-1:0];

endmodule

// File: tb/tb_count_step_monitor.sv
// Directed bench for count_step_monitor; expectations adapt to STEP_MON_ERR_EN.
module tb_count_step_monitor;

`ifdef STEP_MON_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Count = '0;
    logic       UpOrDown = 1'b0;
    logic       CntReset = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [3:0] evt_cnt;
    logic       evt_ready = 1'b1;
    logic [7:0] up_wraps;
    logic [7:0] dn_wraps;
    logic [7:0] err_cnt;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];
    logic [5:0] exp_e;

    always #5 Clk = ~Clk;

    count_step_monitor dut (
        .Clk       (Clk),
        .reset     (reset),
        .Count     (Count),
        .UpOrDown  (UpOrDown),
        .CntReset  (CntReset),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_cnt   (evt_cnt),
        .evt_ready (evt_ready),
        .up_wraps  (up_wraps),
        .dn_wraps  (dn_wraps),
        .err_cnt   (err_cnt),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample, let the edge take it, then sample outputs 1ns later.
    task automatic tick(input logic [3:0] c, input logic d, input logic r);
        Count    = c;
        UpOrDown = d;
        CntReset = r;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_up(input int from, input int to);
        for (int v = from; v <= to; v++) tick(4'(v), 1'b1, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, evt_valid, 0);
        check({tag, "_code"},  evt_code,  0);
        check({tag, "_cnt"},   evt_cnt,   0);
        check({tag, "_up"},    up_wraps,  0);
        check({tag, "_dn"},    dn_wraps,  0);
        check({tag, "_err"},   err_cnt,   0);
        check({tag, "_ovf"},   ovf,       0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b0;
        tick(4'd0, 1'b1, 1'b0);
        tick(4'd0, 1'b1, 1'b0);
        check_zero("reset");

        // Free-running up count with one wrap
        reset = 1'b1;
        tick(4'd0, 1'b1, 1'b0);
        check("prime_valid", evt_valid, 0);
        run_up(1, 15);
        check("pre_wrap_valid", evt_valid, 0);
        tick(4'd0, 1'b1, 1'b0);
        check("wrap_up_valid", evt_valid, 1);
        check("wrap_up_code", evt_code, 0);
        check("wrap_up_cnt", evt_cnt, 0);
        check("wrap_up_tally", up_wraps, 1);
        check("wrap_up_err", err_cnt, 0);
        tick(4'd1, 1'b1, 1'b0);
        check("wrap_up_popped", evt_valid, 0);

        // Turn around and count down through zero
        tick(4'd2, 1'b1, 1'b0);
        tick(4'd3, 1'b0, 1'b0);
        tick(4'd2, 1'b0, 1'b0);
        tick(4'd1, 1'b0, 1'b0);
        tick(4'd0, 1'b0, 1'b0);
        check("pre_dn_valid", evt_valid, 0);
        tick(4'd15, 1'b0, 1'b0);
        check("wrap_dn_valid", evt_valid, 1);
        check("wrap_dn_code", evt_code, 1);
        check("wrap_dn_cnt", evt_cnt, 15);
        check("wrap_dn_tally", dn_wraps, 1);
        tick(4'd14, 1'b0, 1'b0);
        check("wrap_dn_popped", evt_valid, 0);

        // Error classes: 14->5 jump, 5->6 against down, 6->5 legal, 5->9 jump
        tick(4'd5, 1'b0, 1'b0);
        check("jump1_valid", evt_valid, ERR_EN);
        check("jump1_code", evt_code, ERR_EN ? 3 : 0);
        check("jump1_err", err_cnt, ERR_EN ? 1 : 0);
        tick(4'd6, 1'b0, 1'b0);
        check("dir_err_valid", evt_valid, ERR_EN);
        check("dir_err_code", evt_code, ERR_EN ? 2 : 0);
        check("dir_err_cnt", evt_cnt, ERR_EN ? 6 : 0);
        check("dir_err_err", err_cnt, ERR_EN ? 2 : 0);
        tick(4'd5, 1'b0, 1'b0);
        check("legal_dn_valid", evt_valid, 0);
        tick(4'd9, 1'b0, 1'b0);
        check("jump2_valid", evt_valid, ERR_EN);
        check("jump2_code", evt_code, ERR_EN ? 3 : 0);
        check("jump2_cnt", evt_cnt, ERR_EN ? 9 : 0);
        check("jump2_err", err_cnt, ERR_EN ? 3 : 0);
        tick(4'd8, 1'b0, 1'b0);

        // Counter held in reset: 7 then zeros, then release and count up
        tick(4'd7, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) tick(4'd0, 1'b0, 1'b1);
        check("cntreset_valid", evt_valid, 0);
        check("cntreset_err", err_cnt, ERR_EN ? 3 : 0);
        tick(4'd0, 1'b1, 1'b0);
        tick(4'd1, 1'b1, 1'b0);
        check("release_valid", evt_valid, 0);
        check("release_up", up_wraps, 1);
        check("release_dn", dn_wraps, 1);

        // Overflow: five wraps with the consumer stalled
        evt_ready = 1'b0;
        run_up(2, 15);
        tick(4'd0, 1'b0, 1'b0);  exp_q.push_back({2'd0, 4'd0});
        tick(4'd15, 1'b0, 1'b0); exp_q.push_back({2'd1, 4'd15});
        tick(4'd14, 1'b1, 1'b0);
        tick(4'd15, 1'b1, 1'b0);
        tick(4'd0, 1'b0, 1'b0);  exp_q.push_back({2'd0, 4'd0});
        tick(4'd15, 1'b0, 1'b0); exp_q.push_back({2'd1, 4'd15});
        check("full_ovf", ovf, 0);
        tick(4'd14, 1'b1, 1'b0);
        tick(4'd15, 1'b1, 1'b0);
        tick(4'd0, 1'b1, 1'b0);
        check("drop_ovf", ovf, 1);
        check("drop_up", up_wraps, 4);
        check("drop_dn", dn_wraps, 3);
        evt_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_e = exp_q.pop_front();
            check("drain_valid", evt_valid, 1);
            check("drain_code", evt_code, exp_e[5:4]);
            check("drain_cnt", evt_cnt, exp_e[3:0]);
            tick(4'(j + 1), 1'b1, 1'b0);
        end
        check("drained_valid", evt_valid, 0);

        // Reset clears the sticky overflow and tallies
        reset = 1'b0;
        tick(4'd4, 1'b1, 1'b0);
        check_zero("reset2");

        // Fill to four, then push and pop on the same edge
        reset = 1'b1;
        evt_ready = 1'b0;
        tick(4'd4, 1'b1, 1'b0);
        run_up(5, 15);
        tick(4'd0, 1'b0, 1'b0);  exp_q.push_back({2'd0, 4'd0});
        tick(4'd15, 1'b0, 1'b0); exp_q.push_back({2'd1, 4'd15});
        tick(4'd14, 1'b1, 1'b0);
        tick(4'd15, 1'b1, 1'b0);
        tick(4'd0, 1'b0, 1'b0);  exp_q.push_back({2'd0, 4'd0});
        tick(4'd15, 1'b0, 1'b0); exp_q.push_back({2'd1, 4'd15});
        tick(4'd14, 1'b1, 1'b0);
        tick(4'd15, 1'b1, 1'b0);
        check("stall_head_code", evt_code, 0);
        check("stall_head_cnt", evt_cnt, 0);
        evt_ready = 1'b1;
        tick(4'd0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back({2'd0, 4'd0});
        check("pushpop_ovf", ovf, 0);
        check("pushpop_up", up_wraps, 3);
        check("pushpop_dn", dn_wraps, 2);
        for (int j = 0; j < 4; j++) begin
            exp_e = exp_q.pop_front();
            check("pp_drain_valid", evt_valid, 1);
            check("pp_drain_code", evt_code, exp_e[5:4]);
            check("pp_drain_cnt", evt_cnt, exp_e[3:0]);
            tick(4'(j + 1), 1'b1, 1'b0);
        end
        check("pp_drained_valid", evt_valid, 0);

        // Reset with an event still queued
        evt_ready = 1'b0;
        run_up(5, 15);
        tick(4'd0, 1'b1, 1'b0);
        check("midstream_valid", evt_valid, 1);
        check("midstream_up", up_wraps, 4);
        reset = 1'b0;
        tick(4'd1, 1'b1, 1'b0);
        check_zero("reset3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
